// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper.
//   state_t     : sweep FSM states (IDLE, RUN, DONE)
//   N_IN, N_VEC : inputs of the function under test and number of vectors
//   TT_NOR_AND  : reference truth table of D = ~((A|B)&C), bit i = vector i
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_IN  = 3;
    localparam int N_VEC = 8;

    localparam logic [7:0] TT_NOR_AND = 8'h57;

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// settle_timer: loadable 4-bit up-counter that measures how long a stimulus
// vector has been held.
//   clk    in  rising-edge clock
//   rst    in  asynchronous active-high reset
//   load   in  restart the count from zero on this edge
//   limit  in  count value at which the timer reports expiry
//   expire out high while the count equals limit
module settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] limit,
    output logic       expire
);

    logic [3:0] cnt;

    assign expire = (cnt == limit);

    // The count parks at limit so it can never wrap while nobody reloads it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= 4'd0;
        end else if (!expire) begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all 8 input vectors of a 3-input Boolean
// function in ascending order, samples its output after SETTLE_CYCLES extra
// cycles per vector, and compares the assembled table with an expected one.
//   clk, rst  clock and asynchronous active-high reset
//   start     one-cycle sweep request, accepted only in IDLE
//   expected  expected truth table, captured when start is accepted
//   dut_out   output of the function under test
//   stim      vector driven to the function, {A,B,C}
//   busy      high while a sweep is running
//   done      one-cycle pulse when a sweep completes
//   result    measured truth table of the last completed sweep
//   mismatch  result ^ captured expected table
//   pass      high when mismatch is zero
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      expected,
    input  logic            dut_out,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic [7:0]      result,
    output logic [7:0]      mismatch,
    output logic            pass
);

    localparam logic [3:0]      SETTLE_LIMIT = 4'(SETTLE_CYCLES);
    localparam logic [N_IN-1:0] LAST_IDX     = N_IN'(N_VEC - 1);

    state_t          state;
    state_t          next_state;
    logic [N_IN-1:0] idx;
    logic [7:0]      exp_cap;
    logic [7:0]      shadow;
    logic [7:0]      shadow_next;
    logic            timer_load;
    logic            expire;
    logic            accept;
    logic            sample;
    logic            step;
    logic            finish;

    settle_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .limit  (SETTLE_LIMIT),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The timer is reloaded both when a sweep starts and whenever the index
    // advances, so every vector gets the same hold time.
    always_comb begin
        next_state = state;
        timer_load = 1'b0;
        accept     = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                    timer_load = 1'b1;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                if (expire) begin
                    if (idx == LAST_IDX) begin
                        next_state = DONE;
                        finish     = 1'b1;
                    end else begin
                        step       = 1'b1;
                        timer_load = 1'b1;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign sample = (state == RUN) && expire;

    // Shadow table including the bit sampled this cycle; on the final sample
    // this is the complete table, so result is loaded from it directly.
    always_comb begin
        shadow_next      = shadow;
        shadow_next[idx] = dut_out;
    end

    // result/mismatch/pass only change on the RUN->DONE edge, so a sweep in
    // progress never exposes a partial table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            stim     <= '0;
            exp_cap  <= 8'd0;
            shadow   <= 8'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= 8'd0;
            mismatch <= 8'd0;
            pass     <= 1'b0;
        end else begin
            busy <= (next_state == RUN);
            done <= (next_state == DONE);
            if (accept) begin
                idx     <= '0;
                stim    <= '0;
                exp_cap <= expected;
                shadow  <= 8'd0;
            end
            if (sample) begin
                shadow <= shadow_next;
            end
            if (step) begin
                idx  <= idx + 1'b1;
                stim <= idx + 1'b1;
            end
            if (finish) begin
                result   <= shadow_next;
                mismatch <= shadow_next ^ exp_cap;
                pass     <= (shadow_next == exp_cap);
            end
            if (state == DONE) begin
                stim <= '0;
            end
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper. Three instances with settle
// times 2, 0 and 15 share clock and reset; each is fed by a behavioural
// model of D = ~((A|B)&C) that can be forced stuck-at or given a flipped
// vector 3.
module tb_truth_table_sweeper;

    logic       clk;
    logic       rst;
    logic [1:0] fault_mode;

    logic       start2, start0, start15;
    logic [7:0] expected2, expected0, expected15;
    logic       dut_out2, dut_out0, dut_out15;
    logic [2:0] stim2, stim0, stim15;
    logic       busy2, busy0, busy15;
    logic       done2, done0, done15;
    logic [7:0] result2, result0, result15;
    logic [7:0] mismatch2, mismatch0, mismatch15;
    logic       pass2, pass0, pass15;

    int checks;
    int errors;

    // Function under test: 0 correct, 1 stuck-at-0, 2 stuck-at-1,
    // 3 correct except vector 3 inverted.
    function automatic logic fut(input logic [2:0] s, input logic [1:0] m);
        logic d;
        d = ~((s[2] | s[1]) & s[0]);
        case (m)
            2'd1:    return 1'b0;
            2'd2:    return 1'b1;
            2'd3:    return d ^ (s == 3'd3);
            default: return d;
        endcase
    endfunction

    assign dut_out2  = fut(stim2, fault_mode);
    assign dut_out0  = fut(stim0, fault_mode);
    assign dut_out15 = fut(stim15, fault_mode);

    truth_table_sweeper #(.SETTLE_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .expected(expected2),
        .dut_out(dut_out2), .stim(stim2), .busy(busy2), .done(done2),
        .result(result2), .mismatch(mismatch2), .pass(pass2)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .expected(expected0),
        .dut_out(dut_out0), .stim(stim0), .busy(busy0), .done(done0),
        .result(result0), .mismatch(mismatch0), .pass(pass0)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(15)) dut15 (
        .clk(clk), .rst(rst), .start(start15), .expected(expected15),
        .dut_out(dut_out15), .stim(stim15), .busy(busy15), .done(done15),
        .result(result15), .mismatch(mismatch15), .pass(pass15)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", tag, got, want);
        end
    endtask

    // One sweep on the S=2 instance. Optionally checks stim/busy every cycle,
    // checks that result holds a previous value while running, and injects
    // ignored start pulses plus a late change of expected.
    task automatic applyStimulus(input logic [1:0] mode, input logic [7:0] exp_tab,
                                 input bit chk_stim, input bit chk_hold,
                                 input logic [7:0] hold_val, input bit inject,
                                 output int done_edge);
        fault_mode = mode;
        expected2  = exp_tab;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        checkOutput("busy_at_e0", busy2, 1);
        checkOutput("stim_at_e0", stim2, 0);
        done_edge = -1;
        for (int n = 1; n <= 40; n++) begin
            if (inject) begin
                start2 = (n == 5) || (n == 23);
                if (n == 3) expected2 = 8'h00;
            end
            @(posedge clk);
            #1;
            if (done2) begin
                done_edge = n;
                break;
            end
            if (chk_stim) begin
                checkOutput("stim_step", stim2, 32'(n / 3));
                checkOutput("busy_run", busy2, 1);
            end
            if (chk_hold) checkOutput("result_hold", result2, hold_val);
        end
        start2 = 1'b0;
        checkOutput("busy_at_done", busy2, 0);
        if (inject) begin
            // start during the DONE cycle must be dropped, not queued
            start2 = 1'b1;
            @(posedge clk);
            #1;
            start2 = 1'b0;
            checkOutput("start_in_done_ignored", busy2, 0);
            @(posedge clk);
            #1;
            checkOutput("start_not_queued", busy2, 0);
        end else begin
            @(posedge clk);
            #1;
        end
        checkOutput("done_one_cycle", done2, 0);
        checkOutput("stim_back_to_0", stim2, 0);
    endtask

    initial begin
        int lat;
        bit saw_done;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        fault_mode = 2'd0;
        start2 = 1'b0; start0 = 1'b0; start15 = 1'b0;
        expected2 = 8'h00; expected0 = 8'h00; expected15 = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_stim", stim2, 0);
        checkOutput("rst_busy", busy2, 0);
        checkOutput("rst_done", done2, 0);
        checkOutput("rst_result", result2, 0);
        checkOutput("rst_mismatch", mismatch2, 0);
        checkOutput("rst_pass", pass2, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] correct function, S=2");
        applyStimulus(2'd0, 8'h57, 1'b1, 1'b0, 8'h00, 1'b0, lat);
        checkOutput("lat_s2", lat, 24);
        checkOutput("ok_result", result2, 8'h57);
        checkOutput("ok_mismatch", mismatch2, 8'h00);
        checkOutput("ok_pass", pass2, 1);

        $display("[TB] stuck-at-0");
        applyStimulus(2'd1, 8'h57, 1'b0, 1'b0, 8'h00, 1'b0, lat);
        checkOutput("sa0_result", result2, 8'h00);
        checkOutput("sa0_mismatch", mismatch2, 8'h57);
        checkOutput("sa0_pass", pass2, 0);

        $display("[TB] stuck-at-1");
        applyStimulus(2'd2, 8'h57, 1'b0, 1'b0, 8'h00, 1'b0, lat);
        checkOutput("sa1_result", result2, 8'hFF);
        checkOutput("sa1_mismatch", mismatch2, 8'hA8);
        checkOutput("sa1_pass", pass2, 0);

        $display("[TB] ignored starts and late expected change");
        applyStimulus(2'd0, 8'h57, 1'b1, 1'b0, 8'h00, 1'b1, lat);
        checkOutput("inj_lat", lat, 24);
        checkOutput("inj_result", result2, 8'h57);
        checkOutput("inj_pass", pass2, 1);

        $display("[TB] two sweeps, vector 3 flipped on the second");
        applyStimulus(2'd0, 8'h57, 1'b0, 1'b0, 8'h00, 1'b0, lat);
        checkOutput("first_result", result2, 8'h57);
        applyStimulus(2'd3, 8'h57, 1'b0, 1'b1, 8'h57, 1'b0, lat);
        checkOutput("flip_result", result2, 8'h5F);
        checkOutput("flip_mismatch", mismatch2, 8'h08);
        checkOutput("flip_pass", pass2, 0);

        $display("[TB] reset during vector 4");
        fault_mode = 2'd0;
        expected2  = 8'h57;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        checkOutput("pre_rst_stim", stim2, 4);
        rst = 1'b1;
        #1;
        checkOutput("midrst_stim", stim2, 0);
        checkOutput("midrst_busy", busy2, 0);
        checkOutput("midrst_done", done2, 0);
        checkOutput("midrst_result", result2, 0);
        checkOutput("midrst_mismatch", mismatch2, 0);
        checkOutput("midrst_pass", pass2, 0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (done2 || busy2) saw_done = 1'b1;
        end
        checkOutput("no_done_after_rst", saw_done, 0);
        applyStimulus(2'd0, 8'h57, 1'b0, 1'b0, 8'h00, 1'b0, lat);
        checkOutput("post_rst_lat", lat, 24);
        checkOutput("post_rst_result", result2, 8'h57);

        $display("[TB] S=0");
        fault_mode = 2'd0;
        expected0  = 8'h57;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done0) begin
                lat = n;
                break;
            end
        end
        checkOutput("lat_s0", lat, 8);
        checkOutput("s0_result", result0, 8'h57);
        checkOutput("s0_pass", pass0, 1);

        $display("[TB] S=15");
        expected15 = 8'h57;
        @(negedge clk);
        start15 = 1'b1;
        @(posedge clk);
        #1;
        start15 = 1'b0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (done15) begin
                lat = n;
                break;
            end
        end
        checkOutput("lat_s15", lat, 128);
        checkOutput("s15_result", result15, 8'h57);
        checkOutput("s15_mismatch", mismatch15, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
